ahb_dma_master: RTL and testbench
=================================

Name: ahb_dma_master

Overview:
- Single-channel word-copy engine that acts as an AHB-Lite bus master (initiator), the opposite role to the ROM, RAM, GPIO, UART and display slaves.
- It copies `word_count` 32-bit words from `src_addr` to `dst_addr`, one read then one write per word, with non-pipelined transfers.
- The control inputs come from a register slave on the CPU bus. The bus-side ports connect to a master port of the bus fabric (decoder/mux) that serves the system slaves.

Parameters:
- CNT_W, 16, width of the word count and progress counter
- HPROT_VAL, 4'b0011, constant driven on HPROT (privileged data access)

Ports:
- HCLK  in  1  bus clock (50 MHz)
- HRESETn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a copy; ignored while busy
- src_addr  in  32  source byte address; bits [1:0] ignored (forced 0)
- dst_addr  in  32  destination byte address; bits [1:0] ignored (forced 0)
- word_count  in  CNT_W  number of words to copy; 0 is legal
- busy  out  1  copy in progress
- done  out  1  one-cycle pulse when a copy ends, normal or error
- error  out  1  sticky error flag; cleared by next accepted start
- words_done  out  CNT_W  words completely written in the current/last copy
- HADDR  out  32  bus address
- HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only
- HWRITE  out  1  write transfer
- HSIZE  out  3  constant 3'b010 (word)
- HPROT  out  4  constant HPROT_VAL
- HWDATA  out  32  write data
- HRDATA  in  32  read data
- HREADY  in  1  transfer completes / slave ready
- HRESP  in  1  error response from slave

Behaviour:
- Reset is asynchronous and active-low on HRESETn; no other reset. While HRESETn is low:
  - HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, error=0, words_done=0, state=IDLE.
  - Reset mid-copy aborts immediately: no done pulse, no further transfers.
- State machine: IDLE, RD_A, RD_D, WR_A, WR_D, FIN.
- IDLE:
  - HTRANS=IDLE.
  - On start=1 at a clock edge: latch src, dst and count; clear error and words_done.
  - Go to FIN if count==0, else RD_A.
- RD_A:
  - HADDR=src, HWRITE=0, HTRANS=NONSEQ. These are held stable until an edge with HREADY=1, then go to RD_D.
- RD_D:
  - HTRANS=IDLE.
  - At an edge with HREADY=1: capture HRDATA into a 32-bit buffer and go to WR_A.
- WR_A:
  - HADDR=dst, HWRITE=1, HTRANS=NONSEQ, held until HREADY=1, then go to WR_D.
- WR_D:
  - HTRANS=IDLE, HWDATA=buffer, held stable until HREADY=1.
  - On completion: words_done+1, src+4, dst+4 (mod 2^32, wrap-around silent).
  - Go to FIN if words_done+1==count, else RD_A.
- FIN: done=1 for exactly this cycle, busy=0 next cycle, return to IDLE.
- busy=1 in every state except IDLE.
- Error handling:
  - If HRESP=1 is seen during RD_D or WR_D, set error=1.
  - At the following HREADY=1 edge go to FIN with no further transfers. A failed write does not increment words_done.
- Timing with zero wait states: 4 cycles per word. The start edge is edge 0; done is high in the cycle after edge 4N. For count=0, done is high in the cycle after the start edge.
- start while busy (including during FIN) is ignored; the latched parameters are unaffected.
- Transfer ordering: an address phase is never issued while a data phase is pending, so the master never pipelines.

Test Plan:
1. src=0x2000_0000, dst=0x2000_0100, count=3, zero-wait RAM model preloaded 0x11,0x22,0x33 -> dst words read back 0x11,0x22,0x33; done in cycle after edge 12; words_done=3; error=0.
2. Same copy with the slave inserting 2 wait states on every data phase -> HADDR/HWDATA stable during waits; done after edge 4·3+2·6=24; data correct.
3. count=0, start=1 -> no NONSEQ ever driven; done pulse in cycle after start edge; words_done=0.
4. Slave returns two-cycle HRESP on 2nd write of count=4 -> error=1, words_done=1, done pulses, no transfer to dst+8 or beyond; next start clears error.
5. start re-asserted mid-copy with different addresses -> ignored; original copy completes unchanged.
6. HRESETn pulled low during WR_A of word 2 -> HTRANS=00 and busy=0 asynchronously, no done pulse; a fresh start after release copies correctly. Also src=0xFFFF_FFFC, count=2 -> second read at 0x0000_0000.

Source files
------------

// File: rtl/ahb_dma_master.sv
// ahb_dma_master
// ---------------------------------------------------------------------------
// Single-channel word-copy engine acting as an AHB-Lite master. Copies
// word_count 32-bit words from src_addr to dst_addr, one read followed by one
// write per word. Transfers are never pipelined: a new address phase is only
// issued once the previous data phase has completed.
//
// Ports
//   HCLK, HRESETn        bus clock, asynchronous active-low reset
//   start                one-cycle copy request (ignored while busy)
//   src_addr, dst_addr   byte addresses, bits [1:0] forced to zero
//   word_count           number of words to copy (0 is legal)
//   busy                 high in every state except IDLE
//   done                 one-cycle pulse when a copy ends (normal or error)
//   error                sticky error flag, cleared by the next accepted start
//   words_done           words fully written in the current/last copy
//   HADDR..HWDATA        AHB-Lite master outputs (HSIZE/HPROT constant)
//   HRDATA, HREADY, HRESP AHB-Lite slave responses
//   dbg_state            current FSM state for checkers
//
// Handshake: an address phase (HTRANS=NONSEQ) is accepted at the first rising
// edge where HREADY=1; a data phase completes at the first rising edge where
// HREADY=1. Address, control and write data are held stable until then.
// ---------------------------------------------------------------------------
module ahb_dma_master #(
  parameter int         CNT_W     = 16,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_done,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [3:0]       HPROT,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_D = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  localparam logic [1:0] HTRANS_IDLE    = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ  = 2'b10;

  state_t           state_q, state_d;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      buf_q;
  logic [CNT_W-1:0] wd_inc;
  logic             last_word;
  // A data phase ends the copy early if the slave flagged an error either in
  // an earlier wait cycle (already in error) or in the completing cycle.
  logic             fail_now;

  assign wd_inc    = words_done + CNT_W'(1);
  assign last_word = (wd_inc == cnt_q);
  assign fail_now  = HRESP || error;

  assign HSIZE     = 3'b010;
  assign HPROT     = HPROT_VAL;
  assign dbg_state = state_q;

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and bus/status outputs
  always_comb begin
    state_d = state_q;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_FIN);
    HTRANS  = HTRANS_IDLE;
    HADDR   = 32'h0;
    HWRITE  = 1'b0;
    HWDATA  = 32'h0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = (word_count == '0) ? ST_FIN : ST_RD_A;
      end
      ST_RD_A: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = src_q;
        if (HREADY) state_d = ST_RD_D;
      end
      ST_RD_D: begin
        HADDR = src_q;
        if (HREADY) state_d = fail_now ? ST_FIN : ST_WR_A;
      end
      ST_WR_A: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = dst_q;
        HWRITE = 1'b1;
        if (HREADY) state_d = ST_WR_D;
      end
      ST_WR_D: begin
        HADDR  = dst_q;
        HWRITE = 1'b1;
        HWDATA = buf_q;
        if (HREADY) state_d = (fail_now || last_word) ? ST_FIN : ST_RD_A;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: latched parameters, read buffer, progress and error flag
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      src_q      <= 32'h0;
      dst_q      <= 32'h0;
      cnt_q      <= '0;
      buf_q      <= 32'h0;
      words_done <= '0;
      error      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            src_q      <= src_addr & ~32'h3;
            dst_q      <= dst_addr & ~32'h3;
            cnt_q      <= word_count;
            words_done <= '0;
            error      <= 1'b0;
          end
        end
        ST_RD_D: begin
          if (HRESP) error <= 1'b1;
          if (HREADY && !fail_now) buf_q <= HRDATA;
        end
        ST_WR_D: begin
          if (HRESP) error <= 1'b1;
          // A failed write does not count as a completed word.
          if (HREADY && !fail_now) begin
            words_done <= wd_inc;
            src_q      <= src_q + 32'd4;
            dst_q      <= dst_q + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_dma_master.sv
// tb_ahb_dma_master
// ---------------------------------------------------------------------------
// Bench for ahb_dma_master: a memory slave with programmable wait states and
// two-cycle error responses, a transaction-level copy model that predicts the
// ordered list of bus transfers and final memory, and a per-cycle monitor.
// ---------------------------------------------------------------------------
module tb_ahb_dma_master;
  localparam int CNT_W = 16;

  // Clock / reset
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;
  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // DUT signals
  logic             start = 1'b0;
  logic [31:0]      src_addr = 32'h0;
  logic [31:0]      dst_addr = 32'h0;
  logic [CNT_W-1:0] word_count = '0;
  logic             busy, done, error;
  logic [CNT_W-1:0] words_done;
  logic [31:0]      HADDR, HWDATA;
  logic [1:0]       HTRANS;
  logic             HWRITE;
  logic [2:0]       HSIZE;
  logic [3:0]       HPROT;
  logic [2:0]       dbg_state;
  logic [31:0]      HRDATA = 32'h0;
  logic             HREADY = 1'b1;
  logic             HRESP = 1'b0;

  ahb_dma_master #(.CNT_W(CNT_W), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .dbg_state(dbg_state)
  );

  // Scoreboard state
  int checks = 0;
  int failures = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [64:0] exp_q[$];            // {hwrite, haddr, expected hwdata}
  bit   active = 1'b0;
  int   start_edge = 0;
  int   fin_cyc = -1;
  int   xfers = 0;
  int   xfers_exp = 0;
  int   low_cnt = 0;
  int   wait_cfg = 0;
  int   err_cfg = -1;
  int   exp_wd = 0;
  bit   exp_err = 1'b0;
  logic [31:0] cur_dst = 32'h0;
  int   cur_n = 0;
  logic exp_busy, exp_done;

  // Slave data-phase tracking
  bit          dp_active = 1'b0;
  bit          dp_write = 1'b0;
  bit          dp_err = 1'b0;
  logic [31:0] dp_addr = 32'h0;
  logic [31:0] dp_wdata = 32'h0;
  int          dp_k = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : mem_default(a);
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  // Response for cycle dp_k of the current data phase: wait_cfg plain waits,
  // then (on an injected error) one cycle HRESP=1/HREADY=0, then completion.
  task automatic slave_phase(output logic r, output logic p, output logic [31:0] d);
    int tot;
    tot = wait_cfg + (dp_err ? 1 : 0);
    d = mem_get(dp_addr);
    if (dp_k < wait_cfg) begin
      r = 1'b0; p = 1'b0;
    end else if (dp_k < tot) begin
      r = 1'b0; p = 1'b1;
    end else begin
      r = 1'b1; p = dp_err;
    end
    if (!r) low_cnt++;
  endtask

  // Memory slave: decides at the negedge, drives just after the next posedge.
  initial begin : slave
    logic n_ready, n_resp;
    logic [31:0] n_rdata;
    logic [64:0] e;
    forever begin
      @(negedge HCLK);
      n_ready = HREADY;
      n_resp  = HRESP;
      n_rdata = HRDATA;
      if (!HRESETn) begin
        dp_active = 1'b0;
        n_ready = 1'b1;
        n_resp  = 1'b0;
      end else if (dp_active) begin
        chk("no_pipeline", 64'(HTRANS), 64'(2'b00));
        chk("haddr_hold", 64'(HADDR), 64'(dp_addr));
        if (dp_write) chk("hwdata", 64'(HWDATA), 64'(dp_wdata));
        if (HREADY) begin
          if (dp_write && !dp_err) mem[dp_addr] = HWDATA;
          dp_active = 1'b0;
          xfers++;
          if (xfers == xfers_exp) fin_cyc = cyc + 1;
          n_ready = 1'b1;
          n_resp  = 1'b0;
        end else begin
          dp_k++;
          slave_phase(n_ready, n_resp, n_rdata);
        end
      end else if (HTRANS == 2'b10 && HREADY) begin
        dp_write = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xfer: addr=%0h write=%0b (cycle %0d)", HADDR, HWRITE, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("hwrite", 64'(HWRITE), 64'(e[64]));
          chk("haddr", 64'(HADDR), 64'(e[63:32]));
          dp_wdata = e[31:0];
          dp_write = HWRITE;
        end
        dp_active = 1'b1;
        dp_addr = HADDR;
        dp_k = 0;
        dp_err = (xfers == err_cfg);
        slave_phase(n_ready, n_resp, n_rdata);
      end
      @(posedge HCLK);
      #1;
      HREADY = n_ready;
      HRESP  = n_resp;
      HRDATA = n_rdata;
    end
  end

  // Per-cycle monitor
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_error", 64'(error), 64'(0));
      chk("rst_words_done", 64'(words_done), 64'(0));
      chk("rst_htrans", 64'(HTRANS), 64'(0));
      chk("rst_haddr", 64'(HADDR), 64'(0));
      chk("rst_hwrite", 64'(HWRITE), 64'(0));
      chk("rst_hwdata", 64'(HWDATA), 64'(0));
    end else begin
      exp_busy = active && cyc >= start_edge && (fin_cyc < 0 || cyc <= fin_cyc);
      exp_done = active && fin_cyc >= 0 && cyc == fin_cyc;
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("done", 64'(done), 64'(exp_done));
      if (!exp_busy) chk("idle_htrans", 64'(HTRANS), 64'(0));
      else if (HTRANS != 2'b00) chk("htrans_nonseq", 64'(HTRANS), 64'(2'b10));
    end
    chk("hsize", 64'(HSIZE), 64'(3'b010));
    chk("hprot", 64'(HPROT), 64'(4'b0011));
  end

  // Builds the expected transfer list and final memory, then issues start.
  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int w, input int ex);
    logic [31:0] ms, md, ra, wa, data;
    int nx, wd;
    ms = s & ~32'h3;
    md = d & ~32'h3;
    ref_mem = mem;
    exp_q.delete();
    nx = (ex >= 0) ? ex + 1 : 2 * n;
    wd = (ex >= 0) ? ex / 2 : n;
    for (int i = 0; i < n; i++) begin
      ra = ms + 32'(4 * i);
      wa = md + 32'(4 * i);
      data = ref_get(ra);
      if (2 * i < nx) exp_q.push_back({1'b0, ra, 32'h0});
      if (2 * i + 1 < nx) exp_q.push_back({1'b1, wa, data});
      if (i < wd) ref_mem[wa] = data;
    end
    exp_wd = wd;
    exp_err = (ex >= 0);
    cur_dst = md;
    cur_n = n;
    @(negedge HCLK);
    wait_cfg = w;
    err_cfg = ex;
    xfers = 0;
    low_cnt = 0;
    xfers_exp = nx;
    start_edge = cyc + 1;
    fin_cyc = (n == 0) ? cyc + 1 : -1;
    active = 1'b1;
    start = 1'b1;
    src_addr = s;
    dst_addr = d;
    word_count = CNT_W'(n);
    @(negedge HCLK);
    start = 1'b0;
  endtask

  // Waits for the end of the copy (optionally poking start while busy).
  task automatic finish_copy(input int lat_lit, input bit poke);
    int guard;
    guard = 0;
    while (!(fin_cyc >= 0 && cyc > fin_cyc) && guard < 500) begin
      if (poke && (cyc == start_edge + 3 || cyc == fin_cyc)) begin
        start = 1'b1;
        src_addr = $urandom;
        dst_addr = $urandom;
        word_count = CNT_W'($urandom_range(1, 5));
      end else begin
        start = 1'b0;
      end
      @(negedge HCLK);
      guard++;
    end
    start = 1'b0;
    if (guard >= 500) begin
      checks++;
      failures++;
      $display("FAIL copy_timeout: copy did not end within 500 cycles (cycle %0d)", cyc);
    end else begin
      chk("latency", 64'(fin_cyc - start_edge), 64'(2 * xfers_exp + low_cnt));
      if (lat_lit >= 0) chk("latency_lit", 64'(fin_cyc - start_edge), 64'(lat_lit));
    end
    chk("words_done", 64'(words_done), 64'(exp_wd));
    chk("error", 64'(error), 64'(exp_err));
    chk("xfer_count", 64'(xfers), 64'(xfers_exp));
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    for (int i = 0; i < cur_n; i++)
      chk("dst_data", 64'(mem_get(cur_dst + 32'(4 * i))), 64'(ref_get(cur_dst + 32'(4 * i))));
    active = 1'b0;
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [31:0] rs, rd;
    int rn, rw, rex;
    bit rp;
    repeat (3) @(negedge HCLK);
    #2 HRESETn = 1'b1;
    @(negedge HCLK);

    // Basic zero-wait copy of three words
    mem[32'h2000_0000] = 32'h11;
    mem[32'h2000_0004] = 32'h22;
    mem[32'h2000_0008] = 32'h33;
    start_copy(32'h2000_0000, 32'h2000_0100, 3, 0, -1);
    finish_copy(12, 1'b0);
    chk("t1_w0", 64'(mem_get(32'h2000_0100)), 64'(32'h11));
    chk("t1_w1", 64'(mem_get(32'h2000_0104)), 64'(32'h22));
    chk("t1_w2", 64'(mem_get(32'h2000_0108)), 64'(32'h33));

    // Two wait states on every data phase
    start_copy(32'h2000_0000, 32'h2000_0180, 3, 2, -1);
    finish_copy(24, 1'b0);
    chk("t2_w1", 64'(mem_get(32'h2000_0184)), 64'(32'h22));

    // Zero-length copy
    start_copy(32'h3000_0000, 32'h3000_0100, 0, 0, -1);
    finish_copy(0, 1'b0);

    // Error response on the second write of a four-word copy
    start_copy(32'h2000_0000, 32'h2000_0200, 4, 0, 3);
    finish_copy(9, 1'b0);
    chk("t4_words_done", 64'(words_done), 64'(1));
    chk("t4_w0", 64'(mem_get(32'h2000_0200)), 64'(32'h11));
    repeat (2) @(negedge HCLK);
    chk("t4_error_sticky", 64'(error), 64'(1));
    start_copy(32'h2000_0000, 32'h2000_0300, 1, 0, -1);
    chk("t4_error_cleared", 64'(error), 64'(0));
    finish_copy(4, 1'b0);

    // start pulses while busy and during the done cycle are ignored
    start_copy(32'h2000_0000, 32'h2000_0400, 3, 1, -1);
    finish_copy(18, 1'b1);
    chk("t5_w2", 64'(mem_get(32'h2000_0408)), 64'(32'h33));

    // Reset during the write address phase of word 2
    start_copy(32'h2000_0000, 32'h2000_0500, 3, 0, -1);
    while (cyc < start_edge + 6) @(negedge HCLK);
    chk("t6_wr_a_htrans", 64'(HTRANS), 64'(2'b10));
    chk("t6_wr_a_haddr", 64'(HADDR), 64'(32'h2000_0504));
    chk("t6_wr_a_hwrite", 64'(HWRITE), 64'(1));
    #2 HRESETn = 1'b0;
    active = 1'b0;
    #1;
    chk("t6_async_htrans", 64'(HTRANS), 64'(0));
    chk("t6_async_busy", 64'(busy), 64'(0));
    chk("t6_async_done", 64'(done), 64'(0));
    repeat (2) @(negedge HCLK);
    #2 HRESETn = 1'b1;
    exp_q.delete();
    @(negedge HCLK);

    // Address wrap-around after reset release
    start_copy(32'hFFFF_FFFC, 32'h4000_0000, 2, 0, -1);
    finish_copy(8, 1'b0);
    chk("t6_wrap_w0", 64'(mem_get(32'h4000_0000)), 64'(32'hFFFC_0003));
    chk("t6_wrap_w1", 64'(mem_get(32'h4000_0004)), 64'(32'h0000_FFFF));

    // Randomized copies
    repeat (25) begin
      rs = $urandom;
      rd = $urandom;
      rn = $urandom_range(0, 6);
      rw = $urandom_range(0, 3);
      rex = -1;
      if (rn > 0 && $urandom_range(0, 3) == 0) rex = $urandom_range(0, 2 * rn - 1);
      rp = 1'($urandom_range(0, 1));
      start_copy(rs, rd, rn, rw, rex);
      finish_copy(-1, rp);
      repeat ($urandom_range(0, 2)) @(negedge HCLK);
    end

    repeat (2) @(negedge HCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
